dwpe_seq_ctrl: RTL and testbench

// Sequencer for the depthwise PE array (dwpe). For each output tile of a job it loads
// the pixel register array, runs NMAX = KSIZE**2 MAC cycles with NMAX-1 pixel shifts and
// per-cycle weight addresses, then waits for the PE result flag. Results are handed

---
 rtl/dwpe_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_dwpe_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dwpe_seq_ctrl.sv
// Tile sequencer for the depthwise PE array: load, NMAX MAC cycles, wait for result, hand off.
// Optional WAIT timeout with sticky err is enabled by defining DWPE_SEQ_TIMEOUT_EN.
module dwpe_seq_ctrl #(
    parameter int KSIZE   = 3,
    parameter int TW      = 16,
    parameter int TIMEOUT = 64,
    localparam int NMAX   = KSIZE * KSIZE,
    localparam int KW     = (NMAX > 1) ? $clog2(NMAX) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [TW-1:0] tile_cnt,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          pix_load,
    output logic          pix_shift,
    output logic [TW-1:0] pix_addr,
    output logic [KW-1:0] wt_addr,
    output logic          dwpe_ena,
    input  logic          result_valid,
    output logic          out_valid,
    input  logic          out_ready
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_WAIT, S_OUT, S_DONE
    } state_t;

    localparam logic [KW-1:0] K_LAST = KW'(NMAX - 1);

    state_t        state_reg;
    logic [TW-1:0] cnt_reg;
    logic          busy_reg, done_reg, pix_load_reg, pix_shift_reg;
    logic          dwpe_ena_reg, out_valid_reg;
    logic [TW-1:0] pix_addr_reg;    // doubles as the tile index
    logic [KW-1:0] wt_addr_reg;     // doubles as the MAC cycle counter k

`ifdef DWPE_SEQ_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] W_LAST = WCW'(TIMEOUT - 1);
    logic [WCW-1:0] wait_cnt_reg;
    logic           err_reg;
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign pix_load  = pix_load_reg;
    assign pix_shift = pix_shift_reg;
    assign pix_addr  = pix_addr_reg;
    assign wt_addr   = wt_addr_reg;
    assign dwpe_ena  = dwpe_ena_reg;
    assign out_valid = out_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            pix_load_reg  <= 1'b0;
            pix_shift_reg <= 1'b0;
            dwpe_ena_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            pix_addr_reg  <= '0;
            wt_addr_reg   <= '0;
`ifdef DWPE_SEQ_TIMEOUT_EN
            wait_cnt_reg  <= '0;
            err_reg       <= 1'b0;
`endif
        end else begin
            done_reg      <= 1'b0;
            pix_load_reg  <= 1'b0;
            pix_shift_reg <= 1'b0;
            if (abort) begin
                // err deliberately survives an abort
                state_reg     <= S_IDLE;
                busy_reg      <= 1'b0;
                dwpe_ena_reg  <= 1'b0;
                out_valid_reg <= 1'b0;
                pix_addr_reg  <= '0;
                wt_addr_reg   <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start) begin
                            cnt_reg      <= tile_cnt;
                            pix_addr_reg <= '0;
                            wt_addr_reg  <= '0;
                            busy_reg     <= 1'b1;
`ifdef DWPE_SEQ_TIMEOUT_EN
                            err_reg      <= 1'b0;
`endif
                            if (tile_cnt == '0) begin
                                state_reg <= S_DONE;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg    <= S_LOAD;
                                pix_load_reg <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        state_reg    <= S_RUN;
                        dwpe_ena_reg <= 1'b1;
                        wt_addr_reg  <= '0;
                    end
                    S_RUN: begin
                        if (wt_addr_reg == K_LAST) begin
                            state_reg   <= S_WAIT;
                            wt_addr_reg <= '0;
`ifdef DWPE_SEQ_TIMEOUT_EN
                            wait_cnt_reg <= '0;
`endif
                        end else begin
                            wt_addr_reg   <= wt_addr_reg + 1'b1;
                            pix_shift_reg <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (result_valid) begin
                            state_reg     <= S_OUT;
                            dwpe_ena_reg  <= 1'b0;
                            out_valid_reg <= 1'b1;
                        end
`ifdef DWPE_SEQ_TIMEOUT_EN
                        else if (wait_cnt_reg == W_LAST) begin
                            // give up on the whole job; remaining tiles are dropped
                            state_reg    <= S_DONE;
                            dwpe_ena_reg <= 1'b0;
                            err_reg      <= 1'b1;
                            done_reg     <= 1'b1;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        end
`endif
                    end
                    S_OUT: begin
                        if (out_ready) begin
                            out_valid_reg <= 1'b0;
                            if (pix_addr_reg == cnt_reg - TW'(1)) begin
                                state_reg <= S_DONE;
                                done_reg  <= 1'b1;
                            end else begin
                                state_reg    <= S_LOAD;
                                pix_addr_reg <= pix_addr_reg + 1'b1;
                                pix_load_reg <= 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dwpe_seq_ctrl.sv
// Scoreboard bench for dwpe_seq_ctrl: per-tile plans drive a responder, a monitor checks
// each transfer and done pulse against expectations derived from the plan.
module tb_dwpe_seq_ctrl;
    localparam int KSIZE   = 3;
    localparam int TW      = 16;
    localparam int TIMEOUT = 64;
    localparam int NMAX    = KSIZE * KSIZE;
    localparam int KW      = $clog2(NMAX);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [TW-1:0] tile_cnt = '0;
    logic          result_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, done, err, pix_load, pix_shift, dwpe_ena, out_valid;
    logic [TW-1:0] pix_addr;
    logic [KW-1:0] wt_addr;

    dwpe_seq_ctrl #(.KSIZE(KSIZE), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .tile_cnt(tile_cnt),
        .busy(busy), .done(done), .err(err), .pix_load(pix_load), .pix_shift(pix_shift),
        .pix_addr(pix_addr), .wt_addr(wt_addr), .dwpe_ena(dwpe_ena),
        .result_valid(result_valid), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int w; int s; } tile_t;
    typedef struct { int tiles; int err; } job_t;

    tile_t plan_q[$];
    tile_t exp_q[$];
    job_t  done_q[$];
    int    errors = 0;
    int    checks = 0;
    int    xfer_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Responder: plays the PE (result after W wait cycles) and a downstream that stalls S cycles
    initial begin
        int r_ena, r_ov, cw, cs;
        tile_t p;
        r_ena = 0; r_ov = 0; cw = 1; cs = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                result_valid = 1'b0;
                out_ready = 1'b0;
                continue;
            end
            if (pix_load) begin
                if (plan_q.size() > 0) begin
                    p = plan_q.pop_front();
                    cw = p.w; cs = p.s;
                end else begin
                    cw = 1; cs = 0;
                end
                r_ena = 0; r_ov = 0;
            end
            if (dwpe_ena) r_ena++;
            result_valid = dwpe_ena && ((r_ena - NMAX == cw) || (cw == 1 && r_ena == NMAX));
            if (out_valid) begin
                r_ov++;
                out_ready = (r_ov > cs);
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: accumulates per-tile activity and scores transfers and done pulses
    initial begin
        int t_ena, t_shift, t_lat, t_ov;
        bit t_in, wt_bad, prev_done;
        tile_t e;
        job_t j;
        t_ena = 0; t_shift = 0; t_lat = 0; t_ov = 0;
        t_in = 0; wt_bad = 0; prev_done = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                t_in = 0; prev_done = 0;
                continue;
            end
            if (prev_done) chk("busy_after_done", busy, 0);
            prev_done = done;
            if (pix_load) begin
                t_in = 1; t_ena = 0; t_shift = 0; t_lat = 1; t_ov = 0; wt_bad = 0;
            end else if (t_in) begin
                if (dwpe_ena) begin
                    if (t_ena < NMAX && int'(wt_addr) != t_ena) wt_bad = 1;
                    t_ena++;
                end
                if (pix_shift) t_shift++;
                if (out_valid) t_ov++;
                else if (t_ov == 0) t_lat++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_transfer: got tile %0d, expected none", pix_addr);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tile_idx", pix_addr, e.idx);
                        chk("ena_cycles", t_ena, NMAX + e.w);
                        chk("shift_cycles", t_shift, NMAX - 1);
                        chk("wt_addr_seq_bad", wt_bad, 0);
                        chk("load_to_valid", t_lat, 1 + NMAX + e.w);
                        chk("valid_hold", t_ov, e.s + 1);
                    end
                    $display("xfer tile=%0d ena=%0d shifts=%0d lat=%0d hold=%0d",
                             pix_addr, t_ena, t_shift, t_lat, t_ov);
                    xfer_cnt++;
                    t_in = 0;
                end
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done, expected none");
                end else begin
                    j = done_q.pop_front();
                    chk("job_tiles", xfer_cnt, j.tiles);
                    chk("err_at_done", err, j.err);
                    $display("done tiles=%0d err=%0d", xfer_cnt, err);
                end
                xfer_cnt = 0;
            end
        end
    end

    task automatic run_job(input int cnt, input int fw, input int fs, input int to_job);
        tile_t t;
        for (int i = 0; i < cnt; i++) begin
            t.idx = i;
            t.w = (fw > 0) ? fw : int'($urandom_range(1, 4));
            t.s = (fs >= 0) ? fs : int'($urandom_range(0, 3));
            plan_q.push_back(t);
            if (to_job == 0) exp_q.push_back(t);
        end
        done_q.push_back('{(to_job != 0) ? 0 : cnt, to_job});
        @(posedge clk); #1;
        tile_cnt = TW'(cnt);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        tile_cnt = TW'($urandom);
        $display("job start tile_cnt=%0d", cnt);
    endtask

    task automatic wait_done(output int n, output int ena, output int loads);
        n = 0; ena = 0; loads = 0;
        forever begin
            @(negedge clk);
            n++;
            if (dwpe_ena) ena++;
            if (pix_load) loads++;
            if (done) break;
            if (n > 3000) begin
                checks++; errors++;
                $display("FAIL done_wait: got no done in %0d cycles, expected done", n);
                break;
            end
        end
    endtask

    task automatic wait_run_k(input int k);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (dwpe_ena && int'(wt_addr) == k) return;
        end
        checks++; errors++;
        $display("FAIL run_k_wait: got no RUN k=%0d, expected it", k);
    endtask

    task automatic flush();
        plan_q.delete();
        exp_q.delete();
        done_q.delete();
        xfer_cnt = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ena, loads;
        @(negedge clk);
        chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
        chk("rst_err", err, 0);         chk("rst_pix_load", pix_load, 0);
        chk("rst_pix_shift", pix_shift, 0); chk("rst_pix_addr", pix_addr, 0);
        chk("rst_wt_addr", wt_addr, 0); chk("rst_dwpe_ena", dwpe_ena, 0);
        chk("rst_out_valid", out_valid, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // two tiles, result two cycles after RUN, no stall
        run_job(2, 2, 0, 0);
        wait_done(n, ena, loads);
        chk("t1_ena_total", ena, 2 * (NMAX + 2));
        chk("t1_loads", loads, 2);

        // empty job
        run_job(0, 1, 0, 0);
        wait_done(n, ena, loads);
        chk("t2_done_latency", n, 1);
        chk("t2_loads", loads, 0);
        chk("t2_ena", ena, 0);

        // downstream stall of five cycles
        run_job(1, 1, 5, 0);
        wait_done(n, ena, loads);

        // abort at k=4
        plan_q.push_back('{0, 2, 0});
        plan_q.push_back('{1, 2, 0});
        @(posedge clk); #1; tile_cnt = 2; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_run_k(4);
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_dwpe_ena", dwpe_ena, 0);
        chk("abort_pix_shift", pix_shift, 0);
        chk("abort_done", done, 0);
        $display("abort issued");
        repeat (20) @(negedge clk);
        flush();
        run_job(1, 0, -1, 0);
        wait_done(n, ena, loads);

        // start during RUN is ignored
        run_job(1, 3, 0, 0);
        wait_run_k(2);
        tile_cnt = 7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(n, ena, loads);
        repeat (30) @(negedge clk);
        chk("ignored_start_busy", busy, 0);

        // randomized jobs
        for (int r = 0; r < 8; r++) begin
            run_job(int'($urandom_range(1, 4)), 0, -1, 0);
            wait_done(n, ena, loads);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

`ifdef DWPE_SEQ_TIMEOUT_EN
        // result never arrives: timeout, done still pulses, err cleared by next start
        run_job(3, 1000, 0, 1);
        wait_done(n, ena, loads);
        chk("timeout_ena_cycles", ena, NMAX + TIMEOUT);
        chk("timeout_loads", loads, 1);
        plan_q.delete();
        repeat (3) @(negedge clk);
        run_job(1, 2, 1, 0);
        wait_done(n, ena, loads);
`endif

        // async reset mid-job: immediate reset values, no done
        run_job(3, 2, 1, 0);
        repeat (30) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_pix_addr", pix_addr, 0);
        chk("arst_dwpe_ena", dwpe_ena, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_done", done, 0);
        $display("async reset issued");
        @(negedge clk);
        flush();
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("arst_idle_busy", busy, 0);
        chk("leftover_expected", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
